// File: rtl/clm_arb_pkg.sv
// Shared types and constants for the core local memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: per-requester state enum, in-flight tag struct, memory latency
// constant and the round-robin pointer-advance helper.
package clm_arb_pkg;

  // Core local memory answers a fixed one cycle after the request.
  localparam int MEM_LATENCY = 1;

  // Tag id field is sized for up to 16 requesters.
  localparam int TAG_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } req_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                is_write;
  } tag_t;

  // Pointer position just after the winner, wrapping at n.
  function automatic int rr_next(input int winner, input int n);
    return (winner + 1 >= n) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/core_local_memory_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first starting at a pointer.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides what to do with the winner.
//
// Ports:
//   i_req    - one request bit per candidate
//   i_ptr    - index searched first; search continues upward modulo N
//   o_winner - first requesting index found (0 when none)
//   o_any    - at least one request present
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  always_comb begin
    logic [IW-1:0] w_idx;
    w_idx    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/core_local_memory_arbiter.sv
// core_local_memory_arbiter: round-robin sharing of the single-port L1 core
//   local memory among NUM_REQ LSU requesters, one op issued per cycle.
// Latency: request valid -> mem valid 1 cycle, -> req ready pulse 3 cycles.
// Backpressure: one outstanding op per requester; a requester is not
//   re-eligible until both its valids have been seen low after its ready.
//
// Optional feature macro: CLM_ARB_PERF_EN adds perf_grant_count and
//   perf_conflict_count (saturating 32-bit counters).
//
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   req_read_valid/address       - per-requester read requests
//   req_write_valid/address/data - per-requester write requests
//   req_read_ready/data          - read completion pulse and held read data
//   req_write_ready              - write completion pulse
//   mem_read_*/mem_write_*       - single memory port (requests out, responses in)
module core_local_memory_arbiter
  import clm_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req_read_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_read_address,
  input  logic [NUM_REQ-1:0]                   req_write_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_write_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_write_data,
  output logic [NUM_REQ-1:0]                   req_read_ready,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_read_data,
  output logic [NUM_REQ-1:0]                   req_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_WIDTH-1:0]                mem_read_address,
  output logic                                 mem_write_valid,
  output logic [ADDR_WIDTH-1:0]                mem_write_address,
  output logic [DATA_WIDTH-1:0]                mem_write_data,
  input  logic                                 mem_read_ready,
  input  logic [DATA_WIDTH-1:0]                mem_read_data,
`ifdef CLM_ARB_PERF_EN
  output logic [31:0]                          perf_grant_count,
  output logic [31:0]                          perf_conflict_count,
`endif
  input  logic                                 mem_write_ready
);

  localparam int IW = $clog2(NUM_REQ);
  // One stage for the issue register plus one per cycle of memory latency.
  localparam int TAG_STAGES = MEM_LATENCY + 1;

  req_state_t         r_state [NUM_REQ];
  logic [IW-1:0]      r_rr_ptr;
  tag_t               r_tag   [TAG_STAGES];

  logic [NUM_REQ-1:0] w_eligible;
  logic [IW-1:0]      w_winner;
  logic               w_any;
  logic               w_win_wr;
  tag_t               w_tag_out;
  logic [NUM_REQ-1:0] w_rd_hit;
  logic [NUM_REQ-1:0] w_wr_hit;

  // Only idle requesters compete; this is what prevents a second issue while
  // a requester still holds valid after its ready pulse.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = (r_state[i] == IDLE) && (req_read_valid[i] || req_write_valid[i]);
    end
  end

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_picker (
    .i_req    (w_eligible),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // A requester holding both valids gets its write served first.
  assign w_win_wr = req_write_valid[w_winner];

  // Issue stage: memory request, tag and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      r_rr_ptr          <= '0;
      for (int s = 0; s < TAG_STAGES; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      mem_read_valid  <= w_any && !w_win_wr;
      mem_write_valid <= w_any && w_win_wr;
      if (w_any && !w_win_wr) begin
        mem_read_address <= req_read_address[w_winner];
      end
      if (w_any && w_win_wr) begin
        mem_write_address <= req_write_address[w_winner];
        mem_write_data    <= req_write_data[w_winner];
      end
      r_tag[0] <= '{valid: w_any, id: TAG_ID_W'(w_winner), is_write: w_win_wr};
      for (int s = 1; s < TAG_STAGES; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      if (w_any) begin
        r_rr_ptr <= IW'(rr_next(int'(w_winner), NUM_REQ));
      end
    end
  end

  // The last tag stage lines up with the memory response. A response whose
  // type disagrees with the tag, or that has no live tag, is dropped.
  assign w_tag_out = r_tag[TAG_STAGES-1];

  always_comb begin
    w_rd_hit = '0;
    w_wr_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rd_hit[i] = mem_read_ready && w_tag_out.valid && !w_tag_out.is_write &&
                    (w_tag_out.id == TAG_ID_W'(i));
      w_wr_hit[i] = mem_write_ready && w_tag_out.valid && w_tag_out.is_write &&
                    (w_tag_out.id == TAG_ID_W'(i));
    end
  end

  // Response stage: ready pulses and held read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_read_ready  <= '0;
      req_write_ready <= '0;
      req_read_data   <= '0;
    end else begin
      req_read_ready  <= w_rd_hit;
      req_write_ready <= w_wr_hit;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_rd_hit[i]) begin
          req_read_data[i] <= mem_read_data;
        end
      end
    end
  end

  // Per-requester state. DONE is left only once both valids are seen low, so a
  // requester that keeps a read valid behind a served write stalls in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_state[i] <= IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case (r_state[i])
          IDLE: begin
            if (w_any && (w_winner == IW'(i))) r_state[i] <= PENDING;
          end
          PENDING: begin
            if (w_rd_hit[i] || w_wr_hit[i]) r_state[i] <= DONE;
          end
          DONE: begin
            if (!req_read_valid[i] && !req_write_valid[i]) r_state[i] <= IDLE;
          end
          default: r_state[i] <= IDLE;
        endcase
      end
    end
  end

`ifdef CLM_ARB_PERF_EN
  localparam int CW = $clog2(NUM_REQ + 1);
  logic [CW-1:0] w_elig_cnt;

  always_comb begin
    w_elig_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig_cnt = w_elig_cnt + CW'(w_eligible[i]);
    end
  end

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant_count    <= '0;
      perf_conflict_count <= '0;
    end else begin
      if (w_any && (perf_grant_count != '1)) begin
        perf_grant_count <= perf_grant_count + 32'd1;
      end
      if ((w_elig_cnt >= CW'(2)) && (perf_conflict_count != '1)) begin
        perf_conflict_count <= perf_conflict_count + 32'd1;
      end
    end
  end
`endif

endmodule
